// File: rtl/key_debounce_pkg.sv
// Shared constants for the push-button conditioning block.
// Production defaults assume a 50 MHz clock and a 20 ms debounce window.
package key_pkg;

  localparam int KEY_N_KEYS          = 4;
  localparam int KEY_DEBOUNCE_CYCLES = 1000000;
  localparam int KEY_CNT_W           = 20;

  // Short window so simulations do not spend a million cycles per edge
  localparam int KEY_SIM_DEBOUNCE    = 8;

endpackage

// File: rtl/key_debounce_if.sv
// Button-side bundle: raw pins in, conditioned level/pulse/toggle vectors out.
// The master modport is the pin/consumer side; the slave modport is the debouncer.
interface key_debounce_if
  import key_pkg::*;
#(
  parameter int N_KEYS = KEY_N_KEYS
) ();

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_toggle;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_toggle
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_toggle
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, edge pulses
// and a press-toggled latch. Input is already normalised so 1 = pressed.
module key_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             toggle_q, toggle_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign press_o   = stable_q & ~stable_dly_q;
  assign release_o = ~stable_q & stable_dly_q;
  assign toggle_d  = toggle_q ^ press_o;
  assign level_o   = stable_q;
  assign toggle_o  = toggle_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, which the synchroniser chain depends on.
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      toggle_q     <= 1'b0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      toggle_q     <= toggle_d;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// N independent button channels with pin-polarity normalisation in front.
// Outputs are 1 = pressed regardless of how the board wires the buttons.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS          = KEY_N_KEYS,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int CNT_W           = KEY_CNT_W,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  kif
);

  logic [N_KEYS-1:0] raw;
  logic [N_KEYS-1:0] level, press, release_p, toggle;

  assign raw = kif.key_in ^ {N_KEYS{KEY_ACTIVE_LOW}};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (raw[g]),
      .level_o   (level[g]),
      .press_o   (press[g]),
      .release_o (release_p[g]),
      .toggle_o  (toggle[g])
    );
  end

  assign kif.key_level   = level;
  assign kif.key_press   = press;
  assign kif.key_release = release_p;
  assign kif.key_toggle  = toggle;

endmodule
